// File: rtl/arb_pkg.sv
// ============================================================================
// Module   : arb_pkg
// Purpose  : Shared types and constants for the fetch/data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_IF   = 2'd1,
        ARB_D    = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_ID_IF = 1'b0,
        ARB_ID_D  = 1'b1
    } arb_id_t;

    localparam logic [3:0] XFER_WORD = 4'd4;

endpackage : arb_pkg

`default_nettype wire

// File: rtl/arb_pick.sv
// ============================================================================
// Module   : arb_pick
// Purpose  : Combinational grant selection; data wins ties unless fetch starved.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_pick
    import arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic       if_elig,
    input  logic       d_elig,
    input  logic [3:0] starve_cnt,
    output logic       grant_valid,
    output arb_id_t    grant_id
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    always_comb begin
        grant_valid = if_elig | d_elig;
        grant_id    = ARB_ID_D;
        if (if_elig && (!d_elig || (starve_cnt == LIMIT))) begin
            grant_id = ARB_ID_IF;
        end
    end

endmodule : arb_pick

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one variable-latency memory port between fetch and data.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_size,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_size,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_t        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_size_q, mem_size_d;
    logic [31:0]       if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;

    logic              w_if_elig;
    logic              w_d_elig;
    logic              w_grant_valid;
    arb_id_t           w_grant_id;

    // A requester still showing its done pulse is not re-granted on the same request.
    assign w_if_elig = if_req & ~if_done_q;
    assign w_d_elig  = d_req & ~d_done_q;

    arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .if_elig     (w_if_elig),
        .d_elig      (w_d_elig),
        .starve_cnt  (starve_cnt_q),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (w_grant_valid) begin
                    state_d = (w_grant_id == ARB_ID_IF) ? ARB_IF : ARB_D;
                end
            end
            ARB_IF, ARB_D: begin
                if (mem_ack) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_size_d   = mem_size_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_done_d    = 1'b0;
        d_done_d     = 1'b0;
        starve_cnt_d = starve_cnt_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (w_grant_valid) begin
                    mem_req_d = 1'b1;
                    if (w_grant_id == ARB_ID_IF) begin
                        mem_we_d     = 1'b0;
                        mem_size_d   = XFER_WORD;
                        mem_addr_d   = if_addr;
                        starve_cnt_d = 4'd0;
                    end else begin
                        mem_we_d    = d_we;
                        mem_size_d  = d_size;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        if (w_if_elig && (starve_cnt_q != LIMIT)) begin
                            starve_cnt_d = starve_cnt_q + 4'd1;
                        end
                    end
                end
            end
            ARB_IF: begin
                if (mem_ack) begin
                    mem_req_d  = 1'b0;
                    if_rdata_d = mem_rdata[31:0];
                    if_done_d  = 1'b1;
                end
            end
            ARB_D: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    d_done_d  = 1'b1;
                    // Stores leave the last load result visible.
                    if (!mem_we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_size_q   <= 4'd0;
            if_rdata_q   <= 32'd0;
            d_rdata_q    <= '0;
            if_done_q    <= 1'b0;
            d_done_q     <= 1'b0;
            starve_cnt_q <= 4'd0;
        end else begin
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_size_q   <= mem_size_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_done_q    <= if_done_d;
            d_done_q     <= d_done_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_size  = mem_size_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed scoreboard bench for mem_arbiter with a latency-programmable memory.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [3:0]  d_size;
    logic [63:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [3:0]  mem_size;
    logic        mem_ack   = 1'b0;
    logic [63:0] mem_rdata = 64'd0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W       (64),
        .DATA_W       (64),
        .STARVE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_size    (d_size),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_size  (mem_size),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    int n_cmp = 0;
    int n_err = 0;
    int mem_wait = 0;
    int wcnt = 0;
    bit stray_ack = 1'b0;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [3:0]  size;
    } xact_t;

    xact_t       xq[$];
    logic [63:0] ifq[$];
    logic [63:0] dq[$];
    logic [63:0] d_model = 64'd0;

    function automatic logic [63:0] rd_fn(input logic [63:0] a);
        if (a == 64'h40) return 64'h0000_0000_F840_00E1;
        return {a[31:0] ^ 32'hA5A5_0000, ~a[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_if(input logic [63:0] a);
        logic [63:0] r;
        r = rd_fn(a);
        xq.push_back('{we: 1'b0, addr: a, wdata: 64'd0, size: 4'd4});
        ifq.push_back({32'd0, r[31:0]});
    endtask

    task automatic push_d(input logic we, input logic [63:0] a, input logic [63:0] wd,
                          input logic [3:0] sz, input bit expect_done);
        xq.push_back('{we: we, addr: a, wdata: wd, size: sz});
        if (expect_done) begin
            if (!we) d_model = rd_fn(a);
            dq.push_back(d_model);
        end
    endtask

    task automatic wait_done(input bit want_if, input int budget);
        int k;
        k = 0;
        while (!(want_if ? if_done : d_done) && k < budget) begin
            tick();
            k++;
        end
        chk(want_if ? "if_done_wait" : "d_done_wait", 64'(want_if ? if_done : d_done), 64'd1);
    endtask

    // Memory model: acks after mem_wait request cycles, data derived from address.
    always @(negedge clk) begin
        if (stray_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (mem_req) begin
            if (wcnt == mem_wait) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_fn(mem_addr);
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 64'd0;
                wcnt++;
            end
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 64'd0;
            wcnt      = 0;
        end
    end

    logic  req_prev = 1'b0;
    xact_t e;

    // Scoreboard monitor: each new mem_req and each done pulse pops an expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req && !req_prev) begin
                if (xq.size() == 0) begin
                    chk("unexpected_mem_req", 64'(mem_req), 64'd0);
                end else begin
                    e = xq.pop_front();
                    chk("sb_mem_addr", mem_addr, e.addr);
                    chk("sb_mem_we", 64'(mem_we), 64'(e.we));
                    chk("sb_mem_size", 64'(mem_size), 64'(e.size));
                    if (e.we) chk("sb_mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (if_done) begin
                if (ifq.size() == 0) chk("unexpected_if_done", 64'(if_done), 64'd0);
                else                 chk("sb_if_rdata", 64'(if_rdata), ifq.pop_front());
            end
            if (d_done) begin
                if (dq.size() == 0) chk("unexpected_d_done", 64'(d_done), 64'd0);
                else                chk("sb_d_rdata", d_rdata, dq.pop_front());
            end
        end
        req_prev = mem_req;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 64'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 64'd0; d_wdata = 64'd0; d_size = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_mem_size", 64'(mem_size), 64'd0);
        chk("rst_if_done", 64'(if_done), 64'd0);
        chk("rst_d_done", 64'(d_done), 64'd0);
        chk("rst_if_rdata", 64'(if_rdata), 64'd0);
        chk("rst_d_rdata", d_rdata, 64'd0);
        rst = 1'b0;
        tick();

        // Single fetch, ack in first request cycle.
        mem_wait = 0;
        if_req = 1'b1; if_addr = 64'h40; push_if(64'h40);
        tick();
        chk("fetch_c1_mem_req", 64'(mem_req), 64'd1);
        chk("fetch_c1_size", 64'(mem_size), 64'd4);
        chk("fetch_c1_we", 64'(mem_we), 64'd0);
        tick();
        chk("fetch_c2_if_done", 64'(if_done), 64'd1);
        chk("fetch_c2_if_rdata", 64'(if_rdata), 64'hF840_00E1);
        if_req = 1'b0;
        tick();
        chk("fetch_done_pulse", 64'(if_done), 64'd0);
        chk("fetch_c3_mem_req", 64'(mem_req), 64'd0);

        // Tie: data served first, two wait cycles.
        mem_wait = 2;
        if_req = 1'b1; if_addr = 64'h80;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100; d_size = 4'd8;
        push_d(1'b0, 64'h100, 64'd0, 4'd8, 1'b1);
        push_if(64'h80);
        tick();
        chk("tie_c1_data_addr", mem_addr, 64'h100);
        tick(); tick();
        chk("tie_c3_no_done", 64'(d_done), 64'd0);
        tick();
        chk("tie_c4_d_done", 64'(d_done), 64'd1);
        chk("tie_c4_gap", 64'(mem_req), 64'd0);
        d_req = 1'b0;
        tick();
        chk("tie_c5_fetch_req", 64'(mem_req), 64'd1);
        chk("tie_c5_fetch_addr", mem_addr, 64'h80);
        wait_done(1'b1, 10);
        if_req = 1'b0;
        tick();

        // Store leaves d_rdata at the last load value.
        mem_wait = 1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h8; d_wdata = 64'hDEAD; d_size = 4'd8;
        push_d(1'b1, 64'h8, 64'hDEAD, 4'd8, 1'b1);
        tick();
        chk("store_mem_we", 64'(mem_we), 64'd1);
        chk("store_mem_wdata", mem_wdata, 64'hDEAD);
        wait_done(1'b0, 10);
        chk("store_rdata_kept", d_rdata, rd_fn(64'h100));
        d_req = 1'b0; d_we = 1'b0;
        tick();

        // Starvation: fetch contends at each data grant; limit 4 lets fetch win the 5th.
        mem_wait = 0;
        for (int k = 0; k < 4; k++) begin
            d_req = 1'b1; d_addr = 64'h200 + 64'(8 * k); d_size = 4'd8;
            if_req = 1'b1; if_addr = 64'hC0;
            push_d(1'b0, d_addr, 64'd0, 4'd8, 1'b1);
            tick();
            chk("starve_data_wins", mem_addr, 64'h200 + 64'(8 * k));
            if_req = 1'b0;
            wait_done(1'b0, 10);
            tick();
        end
        d_req = 1'b1; d_addr = 64'h220;
        if_req = 1'b1; if_addr = 64'hC0;
        push_if(64'hC0);
        push_d(1'b0, 64'h220, 64'd0, 4'd8, 1'b1);
        tick();
        chk("starve_fetch_wins", mem_addr, 64'hC0);
        wait_done(1'b1, 10);
        if_req = 1'b0;
        wait_done(1'b0, 10);
        tick();
        d_addr = 64'h228;
        if_req = 1'b1; if_addr = 64'hC4;
        push_d(1'b0, 64'h228, 64'd0, 4'd8, 1'b1);
        push_if(64'hC4);
        tick();
        chk("starve_cnt_cleared", mem_addr, 64'h228);
        wait_done(1'b0, 10);
        d_req = 1'b0;
        wait_done(1'b1, 10);
        if_req = 1'b0;
        tick();

        // Asynchronous reset while data waits for ack.
        mem_wait = 5;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300; d_size = 4'd4;
        push_d(1'b0, 64'h300, 64'd0, 4'd4, 1'b0);
        tick();
        chk("rstmid_mem_req_up", 64'(mem_req), 64'd1);
        if_req = 1'b1; if_addr = 64'h140;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rstmid_async_drop", 64'(mem_req), 64'd0);
        d_req = 1'b0;
        tick();
        chk("rstmid_no_d_done", 64'(d_done), 64'd0);
        mem_wait = 0;
        push_if(64'h140);
        rst = 1'b0;
        tick();
        chk("rstmid_fetch_req", 64'(mem_req), 64'd1);
        chk("rstmid_fetch_addr", mem_addr, 64'h140);
        tick();
        chk("rstmid_if_done", 64'(if_done), 64'd1);
        if_req = 1'b0;
        tick();

        // Stray ack while idle.
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        chk("stray_if_done", 64'(if_done), 64'd0);
        chk("stray_d_done", 64'(d_done), 64'd0);
        chk("stray_mem_req", 64'(mem_req), 64'd0);
        tick();
        chk("stray_if_done_2", 64'(if_done), 64'd0);
        chk("stray_d_done_2", 64'(d_done), 64'd0);
        chk("stray_mem_req_2", 64'(mem_req), 64'd0);
        tick();

        chk("sb_xact_drained", 64'(xq.size()), 64'd0);
        chk("sb_if_drained", 64'(ifq.size()), 64'd0);
        chk("sb_d_drained", 64'(dq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mem_arbiter

`default_nettype wire
